mem_model_arb: RTL and testbench
================================

# mem_model_arb

Two-requester arbiter that shares a single burst-capable memory model's write (tx) and read (rx) ports between two Avalon-style requesters. It sits directly in front of the memory model. It handles:
- write bursts, with the grant locked for the full burst;
- read bursts, tracking outstanding reads so returned data goes back to the requester that issued them.

Write and read arbitration run independently and concurrently, matching the model's separate tx/rx ports.

## Interface
Parameters:
- ADDRWIDTH, 32, address width of requester and memory ports
- DATAWIDTH, 32, data width; byteenable is DATAWIDTH/8
- BURSTWIDTH, 12, burstcount width
- RDQ_DEPTH, 8, maximum outstanding read bursts tracked (power of 2)

Ports (mN = m0, m1, identical sets):
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- mN_address  in  ADDRWIDTH  requester address
- mN_write  in  1  write request (one beat per accepted cycle)
- mN_writedata  in  DATAWIDTH  write data
- mN_byteenable  in  DATAWIDTH/8  write byte enables
- mN_read  in  1  read burst command
- mN_burstcount  in  BURSTWIDTH  burst length in beats; 0 is treated as 1
- mN_waitrequest  out  1  stall; a command/beat is accepted when request high and waitrequest low
- mN_readdata  out  DATAWIDTH  read data, broadcast to both requesters
- mN_readdatavalid  out  1  read beat valid for this requester only
- tx_address, tx_write, tx_writedata, tx_byteenable, tx_burstcount  out  as requester  memory write port
- tx_waitrequest  in  1  memory write stall
- rx_address, rx_read, rx_burstcount  out  as requester  memory read command port
- rx_waitrequest  in  1  memory read stall
- rx_readdata  in  DATAWIDTH  memory read data
- rx_readdatavalid  in  1  memory read data valid

## Operation
Write FSM, states WR_IDLE and WR_BURST:
- WR_IDLE selects among requesters with mN_write high.
  - Round-robin: the requester not granted last wins ties.
  - The pointer resets to favour m0.
- The winner's signals pass combinationally to tx_*.
- On an accepted beat (tx_write & ~tx_waitrequest):
  - effective burstcount 1: stay in WR_IDLE and update the pointer;
  - otherwise: go to WR_BURST, owner locked, wr_count = burstcount-1.
- WR_BURST forwards only the owner.
  - Each accepted beat decrements wr_count.
  - The beat that takes wr_count from 1 to 0 returns the FSM to WR_IDLE and sets the pointer to the owner.
  - The non-owner's write requests are held off.
- mN_waitrequest for writes = tx_waitrequest when granted, 1 otherwise.

Read path:
- Per-cycle round-robin between mN_read, using its own pointer, independent of the write pointer.
- The winner drives rx_*.
- A command is accepted when rx_read & ~rx_waitrequest & ~rdq_full. On acceptance, {owner, effective burstcount} is pushed into the tracking queue.
- Queue full blocks both requesters even if a pop occurs in the same cycle.
- Return routing:
  - rx_readdatavalid is routed to mN_readdatavalid of the queue-head owner.
  - A beat counter increments per valid beat.
  - When the counter reaches the head burstcount, the head is popped and the counter clears.
- A requester with both read and write pending is arbitrated on each path independently.
- mN_waitrequest (combined) is high when any asserted request of that requester is not accepted this cycle.

Boundary behaviour:
- rx_readdatavalid with an empty queue: the beat is dropped; neither readdatavalid asserts.
- burstcount 0 is treated as 1 on both paths.
- The requester's burstcount is sampled only on a burst's first beat.

## Timing
- Arbitration and data routing are combinational: zero added latency on commands, write beats and read data.
- Reset (asynchronous, any time):
  - write FSM to WR_IDLE, wr_count 0;
  - both pointers favour m0;
  - queue emptied, beat counter 0.
- During reset, all tx_write/rx_read/mN_readdatavalid outputs are 0 and mN_waitrequest is 1.
- Reset mid-burst abandons the burst. Read data arriving afterwards finds an empty queue and is dropped.
- Simultaneous push and pop in the same cycle is legal when the queue is not full.

## Configuration
- MEM_MODEL_ARB_FIXED_PRI_EN defined:
  - m0 always wins contention on both the write path (at WR_IDLE) and the read path;
  - round-robin pointers are not implemented.
- Undefined (default): round-robin as described above.
- Burst locking and read routing are identical in both builds.

## Test plan
- m0 write burst of 4 beats and m1 single write, both requesting at the same cycle in WR_IDLE -> m0's 4 beats appear contiguously on tx_*; m1's beat is accepted on the next cycle; m1_waitrequest is high for 4 cycles.
- Both requesters issuing back-to-back single writes, with tx_waitrequest low -> grants alternate m0, m1, m0, m1 (with MEM_MODEL_ARB_FIXED_PRI_EN: m0 only until it drops its request).
- m0 reads burst 2 from 0x100, then m1 reads burst 3 from 0x200, memory returning 5 beats -> m0_readdatavalid on beats 1-2, m1_readdatavalid on beats 3-5; queue empty afterwards.
- 8 single-beat reads outstanding (RDQ_DEPTH=8) with no return -> the 9th read is held by waitrequest. It is accepted the cycle after the first readdatavalid pops the queue.
- Reset asserted after beat 2 of a 4-beat m1 write -> tx_write 0 immediately. After release, an m0 single write is granted in its first cycle.
- tx_waitrequest high for 3 cycles mid-burst -> wr_count holds, the owner stays locked, and no beats are lost or duplicated.

Source files
------------

// File: rtl/mem_model_arb.sv
// Two-requester arbiter in front of a burst memory model: locked write bursts on tx_*,
// tracked read bursts on rx_*. Define MEM_MODEL_ARB_FIXED_PRI_EN for fixed m0 priority.
module mem_model_arb #(
  parameter int ADDRWIDTH  = 32,
  parameter int DATAWIDTH  = 32,
  parameter int BURSTWIDTH = 12,
  parameter int RDQ_DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDRWIDTH-1:0]    m0_address,
  input  logic                    m0_write,
  input  logic [DATAWIDTH-1:0]    m0_writedata,
  input  logic [DATAWIDTH/8-1:0]  m0_byteenable,
  input  logic                    m0_read,
  input  logic [BURSTWIDTH-1:0]   m0_burstcount,
  output logic                    m0_waitrequest,
  output logic [DATAWIDTH-1:0]    m0_readdata,
  output logic                    m0_readdatavalid,
  input  logic [ADDRWIDTH-1:0]    m1_address,
  input  logic                    m1_write,
  input  logic [DATAWIDTH-1:0]    m1_writedata,
  input  logic [DATAWIDTH/8-1:0]  m1_byteenable,
  input  logic                    m1_read,
  input  logic [BURSTWIDTH-1:0]   m1_burstcount,
  output logic                    m1_waitrequest,
  output logic [DATAWIDTH-1:0]    m1_readdata,
  output logic                    m1_readdatavalid,
  output logic [ADDRWIDTH-1:0]    tx_address,
  output logic                    tx_write,
  output logic [DATAWIDTH-1:0]    tx_writedata,
  output logic [DATAWIDTH/8-1:0]  tx_byteenable,
  output logic [BURSTWIDTH-1:0]   tx_burstcount,
  input  logic                    tx_waitrequest,
  output logic [ADDRWIDTH-1:0]    rx_address,
  output logic                    rx_read,
  output logic [BURSTWIDTH-1:0]   rx_burstcount,
  input  logic                    rx_waitrequest,
  input  logic [DATAWIDTH-1:0]    rx_readdata,
  input  logic                    rx_readdatavalid
);

  localparam int QAW = $clog2(RDQ_DEPTH);
  localparam logic [0:0] WR_IDLE  = 1'b0;
  localparam logic [0:0] WR_BURST = 1'b1;
  localparam logic [BURSTWIDTH-1:0] BC_ONE = BURSTWIDTH'(1);

  logic [0:0]            wr_state_q, wr_state_d;
  logic                  wr_owner_q, wr_owner_d;
  logic [BURSTWIDTH-1:0] wr_count_q, wr_count_d;
  logic                  wr_gnt, wr_sel, wr_acc, wr_pref, wr_last_beat;
  logic [BURSTWIDTH-1:0] wr_bc_eff;

  logic                  rd_sel, rd_acc, rd_pref;
  logic [BURSTWIDTH-1:0] rd_bc_eff;

  // ---------------- write path ----------------
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_gnt = 1'b0;
    wr_sel = 1'b0;
    if (wr_state_q == WR_IDLE) begin
      if (m0_write && m1_write) begin
        wr_gnt = 1'b1;
        wr_sel = wr_pref;
      end else if (m0_write || m1_write) begin
        wr_gnt = 1'b1;
        wr_sel = m1_write;
      end
    end else begin
      wr_sel = wr_owner_q;
      wr_gnt = wr_owner_q ? m1_write : m0_write;
    end
  end

  assign tx_write      = wr_gnt & ~reset;
  assign tx_address    = wr_sel ? m1_address    : m0_address;
  assign tx_writedata  = wr_sel ? m1_writedata  : m0_writedata;
  assign tx_byteenable = wr_sel ? m1_byteenable : m0_byteenable;
  assign tx_burstcount = wr_sel ? m1_burstcount : m0_burstcount;

  assign wr_acc    = tx_write & ~tx_waitrequest;
  assign wr_bc_eff = (tx_burstcount == '0) ? BC_ONE : tx_burstcount;
  assign wr_last_beat = (wr_state_q == WR_IDLE) ? (wr_bc_eff == BC_ONE) : (wr_count_q == BC_ONE);

  always_comb begin
    wr_state_d = wr_state_q;
    wr_owner_d = wr_owner_q;
    wr_count_d = wr_count_q;
    if (wr_acc) begin
      if (wr_state_q == WR_IDLE) begin
        if (!wr_last_beat) begin
          wr_state_d = WR_BURST;
          wr_owner_d = wr_sel;
          wr_count_d = wr_bc_eff - BC_ONE;
        end
      end else begin
        wr_count_d = wr_count_q - BC_ONE;
        if (wr_last_beat) wr_state_d = WR_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_q <= WR_IDLE;
      wr_owner_q <= 1'b0;
      wr_count_q <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_owner_q <= wr_owner_d;
      wr_count_q <= wr_count_d;
    end
  end

  // ---------------- read command path ----------------
  logic                  rdq_owner_q [RDQ_DEPTH];
  logic [BURSTWIDTH-1:0] rdq_bc_q    [RDQ_DEPTH];
  logic [QAW-1:0]        rdq_wptr_q, rdq_rptr_q;
  logic [QAW:0]          rdq_cnt_q;
  logic [BURSTWIDTH-1:0] rd_beat_q;
  logic                  rdq_full, rdq_empty, ret_valid, rdq_pop, rd_req;

  assign rd_req = m0_read | m1_read;
  assign rd_sel = (m0_read && m1_read) ? rd_pref : m1_read;

  assign rdq_full  = (rdq_cnt_q == (QAW+1)'(RDQ_DEPTH));
  assign rdq_empty = (rdq_cnt_q == '0);

  assign rx_read       = rd_req & ~rdq_full & ~reset;
  assign rx_address    = rd_sel ? m1_address    : m0_address;
  assign rx_burstcount = rd_sel ? m1_burstcount : m0_burstcount;
  assign rd_acc        = rx_read & ~rx_waitrequest;
  assign rd_bc_eff     = (rx_burstcount == '0) ? BC_ONE : rx_burstcount;

  // NOTE: queue payload is not reset; only the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (rd_acc) begin
      rdq_owner_q[rdq_wptr_q] <= rd_sel;
      rdq_bc_q[rdq_wptr_q]    <= rd_bc_eff;
    end
  end

  // ---------------- read return path ----------------
  assign ret_valid = rx_readdatavalid & ~rdq_empty & ~reset;
  assign rdq_pop   = ret_valid & ((rd_beat_q + BC_ONE) == rdq_bc_q[rdq_rptr_q]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdq_wptr_q <= '0;
      rdq_rptr_q <= '0;
      rdq_cnt_q  <= '0;
      rd_beat_q  <= '0;
    end else begin
      if (rd_acc)  rdq_wptr_q <= rdq_wptr_q + QAW'(1);
      if (rdq_pop) rdq_rptr_q <= rdq_rptr_q + QAW'(1);
      case ({rd_acc, rdq_pop})
        2'b10:   rdq_cnt_q <= rdq_cnt_q + (QAW+1)'(1);
        2'b01:   rdq_cnt_q <= rdq_cnt_q - (QAW+1)'(1);
        default: rdq_cnt_q <= rdq_cnt_q;
      endcase
      if (ret_valid) rd_beat_q <= rdq_pop ? '0 : rd_beat_q + BC_ONE;
    end
  end

  assign m0_readdata      = rx_readdata;
  assign m1_readdata      = rx_readdata;
  assign m0_readdatavalid = ret_valid & ~rdq_owner_q[rdq_rptr_q];
  assign m1_readdatavalid = ret_valid &  rdq_owner_q[rdq_rptr_q];

  // ---------------- tie-break priority ----------------
`ifdef MEM_MODEL_ARB_FIXED_PRI_EN
  assign wr_pref = 1'b0;
  assign rd_pref = 1'b0;
`else
  logic wr_last_q, rd_last_q;

  // Pointers hold the last winner; starting at m1 makes m0 win the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_last_q <= 1'b1;
      rd_last_q <= 1'b1;
    end else begin
      if (wr_acc && wr_last_beat) wr_last_q <= wr_sel;
      if (rd_acc)                 rd_last_q <= rd_sel;
    end
  end

  assign wr_pref = ~wr_last_q;
  assign rd_pref = ~rd_last_q;
`endif

  assign m0_waitrequest = reset | (m0_write & ~(wr_acc & ~wr_sel)) | (m0_read & ~(rd_acc & ~rd_sel));
  assign m1_waitrequest = reset | (m1_write & ~(wr_acc &  wr_sel)) | (m1_read & ~(rd_acc &  rd_sel));

endmodule

// File: tb/tb_mem_model_arb.sv
// Directed bench for mem_model_arb (default round-robin build): write table plus read,
// queue-full, mixed-path and reset sequences.
module tb_mem_model_arb;

  logic        clk, reset;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_write, m1_write, m0_read, m1_read;
  logic [11:0] m0_burstcount, m1_burstcount;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] tx_address, tx_writedata, rx_address, rx_readdata;
  logic        tx_write, tx_waitrequest, rx_read, rx_waitrequest, rx_readdatavalid;
  logic [3:0]  tx_byteenable;
  logic [11:0] tx_burstcount, rx_burstcount;

  mem_model_arb dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_burstcount(m0_burstcount),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_burstcount(m1_burstcount),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .tx_address(tx_address), .tx_write(tx_write), .tx_writedata(tx_writedata),
    .tx_byteenable(tx_byteenable), .tx_burstcount(tx_burstcount), .tx_waitrequest(tx_waitrequest),
    .rx_address(rx_address), .rx_read(rx_read), .rx_burstcount(rx_burstcount),
    .rx_waitrequest(rx_waitrequest), .rx_readdata(rx_readdata), .rx_readdatavalid(rx_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_write = 0; m1_write = 0; m0_read = 0; m1_read = 0;
    m0_address = '0; m1_address = '0; m0_burstcount = 12'd1; m1_burstcount = 12'd1;
    m0_writedata = '0; m1_writedata = '0; m0_byteenable = 4'hF; m1_byteenable = 4'h3;
    tx_waitrequest = 0; rx_waitrequest = 0; rx_readdatavalid = 0; rx_readdata = '0;
  endtask

  typedef struct packed {
    logic        m0_w;
    logic [11:0] m0_bc;
    logic [31:0] m0_a;
    logic        m1_w;
    logic [11:0] m1_bc;
    logic [31:0] m1_a;
    logic        tx_wait;
    logic        e_txw;
    logic [31:0] e_addr;
    logic        e_w0;
    logic        e_w1;
  } wvec_t;

  localparam int NV = 23;
  wvec_t vec [NV];

  function automatic wvec_t mk(logic w0, int bc0, int a0, logic w1, int bc1, int a1, logic tw,
                               logic etx, int ea, logic ew0, logic ew1);
    wvec_t v;
    v.m0_w = w0; v.m0_bc = 12'(bc0); v.m0_a = 32'(a0);
    v.m1_w = w1; v.m1_bc = 12'(bc1); v.m1_a = 32'(a1);
    v.tx_wait = tw; v.e_txw = etx; v.e_addr = 32'(ea); v.e_w0 = ew0; v.e_w1 = ew1;
    return v;
  endfunction

  initial begin
    // Contention: m0 4-beat burst vs m1 single, then alternating singles, burstcount 0,
    // a stalled m1 burst with m0 held off, and a 2-beat m1 burst.
    vec[0]  = mk(1, 4, 'h10, 1, 1, 'h20, 0,  1, 'h10, 0, 1);
    vec[1]  = mk(1, 4, 'h10, 1, 1, 'h20, 0,  1, 'h10, 0, 1);
    vec[2]  = mk(1, 4, 'h10, 1, 1, 'h20, 0,  1, 'h10, 0, 1);
    vec[3]  = mk(1, 4, 'h10, 1, 1, 'h20, 0,  1, 'h10, 0, 1);
    vec[4]  = mk(0, 4, 'h10, 1, 1, 'h20, 0,  1, 'h20, 0, 0);
    vec[5]  = mk(1, 1, 'h30, 1, 1, 'h40, 0,  1, 'h30, 0, 1);
    vec[6]  = mk(1, 1, 'h30, 1, 1, 'h40, 0,  1, 'h40, 1, 0);
    vec[7]  = mk(1, 1, 'h30, 1, 1, 'h40, 0,  1, 'h30, 0, 1);
    vec[8]  = mk(1, 1, 'h30, 1, 1, 'h40, 0,  1, 'h40, 1, 0);
    vec[9]  = mk(0, 1, 'h30, 1, 0, 'h40, 0,  1, 'h40, 0, 0);
    vec[10] = mk(1, 0, 'h30, 0, 0, 'h40, 0,  1, 'h30, 0, 0);
    vec[11] = mk(1, 1, 'h30, 1, 1, 'h40, 0,  1, 'h40, 1, 0);
    vec[12] = mk(0, 1, 'h30, 0, 1, 'h40, 0,  0, 'h0,  0, 0);
    vec[13] = mk(0, 1, 'h30, 1, 3, 'h50, 0,  1, 'h50, 0, 0);
    vec[14] = mk(1, 1, 'h30, 1, 3, 'h50, 1,  1, 'h50, 1, 1);
    vec[15] = mk(1, 1, 'h30, 1, 3, 'h50, 1,  1, 'h50, 1, 1);
    vec[16] = mk(1, 1, 'h30, 1, 3, 'h50, 1,  1, 'h50, 1, 1);
    vec[17] = mk(1, 1, 'h30, 1, 3, 'h50, 0,  1, 'h50, 1, 0);
    vec[18] = mk(1, 1, 'h30, 1, 3, 'h50, 0,  1, 'h50, 1, 0);
    vec[19] = mk(1, 1, 'h30, 0, 3, 'h50, 0,  1, 'h30, 0, 0);
    vec[20] = mk(1, 1, 'h30, 1, 2, 'h60, 0,  1, 'h60, 1, 0);
    vec[21] = mk(1, 1, 'h30, 1, 2, 'h60, 0,  1, 'h60, 1, 0);
    vec[22] = mk(1, 1, 'h30, 1, 2, 'h60, 0,  1, 'h30, 0, 1);

    // Reset state with requests asserted and stray read data
    idle_inputs();
    reset = 1;
    m0_write = 1; m1_write = 1; m0_read = 1; m1_read = 1; rx_readdatavalid = 1;
    #3;
    check("rst tx_write", tx_write, 0);
    check("rst rx_read", rx_read, 0);
    check("rst m0_wait", m0_waitrequest, 1);
    check("rst m1_wait", m1_waitrequest, 1);
    check("rst m0_rdv", m0_readdatavalid, 0);
    check("rst m1_rdv", m1_readdatavalid, 0);
    tick();
    reset = 0;
    idle_inputs();

    // Write table
    for (int i = 0; i < NV; i++) begin
      m0_write = vec[i].m0_w; m0_burstcount = vec[i].m0_bc; m0_address = vec[i].m0_a;
      m1_write = vec[i].m1_w; m1_burstcount = vec[i].m1_bc; m1_address = vec[i].m1_a;
      m0_writedata = {16'hD0D0, vec[i].m0_a[15:0]};
      m1_writedata = {16'hD0D0, vec[i].m1_a[15:0]};
      tx_waitrequest = vec[i].tx_wait;
      #1;
      check($sformatf("wv%0d tx_write", i), tx_write, vec[i].e_txw);
      if (vec[i].e_txw) begin
        check($sformatf("wv%0d tx_address", i), tx_address, vec[i].e_addr);
        check($sformatf("wv%0d tx_writedata", i), tx_writedata, {16'hD0D0, vec[i].e_addr[15:0]});
      end
      check($sformatf("wv%0d m0_wait", i), m0_waitrequest, vec[i].e_w0);
      check($sformatf("wv%0d m1_wait", i), m1_waitrequest, vec[i].e_w1);
      tick();
    end
    idle_inputs();
    tick();

    // Read routing: m0 burst 2, m1 burst 3, five returned beats
    m0_read = 1; m0_burstcount = 2; m0_address = 'h100;
    m1_read = 1; m1_burstcount = 3; m1_address = 'h200;
    #1;
    check("rdA cmd0 rx_read", rx_read, 1);
    check("rdA cmd0 rx_address", rx_address, 'h100);
    check("rdA cmd0 rx_burstcount", rx_burstcount, 2);
    check("rdA cmd0 m0_wait", m0_waitrequest, 0);
    check("rdA cmd0 m1_wait", m1_waitrequest, 1);
    tick();
    m0_read = 0;
    #1;
    check("rdA cmd1 rx_address", rx_address, 'h200);
    check("rdA cmd1 rx_burstcount", rx_burstcount, 3);
    check("rdA cmd1 m1_wait", m1_waitrequest, 0);
    tick();
    m1_read = 0;
    for (int b = 0; b < 5; b++) begin
      rx_readdatavalid = 1; rx_readdata = 32'hCAFE_0000 + 32'(b);
      #1;
      check($sformatf("rdA beat%0d m0_rdv", b), m0_readdatavalid, (b < 2) ? 1 : 0);
      check($sformatf("rdA beat%0d m1_rdv", b), m1_readdatavalid, (b >= 2) ? 1 : 0);
      check($sformatf("rdA beat%0d m1_readdata", b), m1_readdata, 32'hCAFE_0000 + 32'(b));
      tick();
    end
    #1;
    check("rdA empty m0_rdv", m0_readdatavalid, 0);
    check("rdA empty m1_rdv", m1_readdatavalid, 0);
    tick();
    rx_readdatavalid = 0;

    // Queue full: 8 single reads, 9th held until the first pop has taken effect
    m0_read = 1;
    for (int k = 0; k < 8; k++) begin
      m0_burstcount = (k % 2 == 0) ? 12'd0 : 12'd1;
      m0_address = 32'h300 + 32'(k);
      #1;
      check($sformatf("rdB cmd%0d m0_wait", k), m0_waitrequest, 0);
      check($sformatf("rdB cmd%0d rx_read", k), rx_read, 1);
      tick();
    end
    m0_address = 'h308; m0_burstcount = 1;
    #1;
    check("rdB full m0_wait", m0_waitrequest, 1);
    check("rdB full rx_read", rx_read, 0);
    tick();
    rx_readdatavalid = 1;
    #1;
    check("rdB pop m0_wait", m0_waitrequest, 1);
    check("rdB pop m0_rdv", m0_readdatavalid, 1);
    tick();
    rx_readdatavalid = 0;
    #1;
    check("rdB after pop m0_wait", m0_waitrequest, 0);
    check("rdB after pop rx_read", rx_read, 1);
    tick();
    m0_read = 0;
    for (int k = 0; k < 8; k++) begin
      rx_readdatavalid = 1;
      #1;
      check($sformatf("rdB ret%0d m0_rdv", k), m0_readdatavalid, 1);
      tick();
    end
    #1;
    check("rdB drained m0_rdv", m0_readdatavalid, 0);
    tick();
    rx_readdatavalid = 0;

    // Same requester on both paths: write accepted, read stalled -> still waiting
    m0_write = 1; m0_read = 1; m0_burstcount = 1; m0_address = 'h80; rx_waitrequest = 1;
    #1;
    check("mix tx_write", tx_write, 1);
    check("mix rx_read", rx_read, 1);
    check("mix m0_wait", m0_waitrequest, 1);
    tick();
    m0_write = 0; rx_waitrequest = 0;
    #1;
    check("mix read-only m0_wait", m0_waitrequest, 0);
    tick();
    m0_read = 0; rx_readdatavalid = 1;
    #1;
    check("mix ret m0_rdv", m0_readdatavalid, 1);
    tick();
    rx_readdatavalid = 0;

    // Reset after beat 2 of a 4-beat m1 write, with an m0 read outstanding
    m1_write = 1; m1_burstcount = 4; m1_address = 'h60;
    m0_read = 1; m0_burstcount = 1; m0_address = 'h500;
    #1;
    check("rst-burst beat1 m1_wait", m1_waitrequest, 0);
    tick();
    m0_read = 0;
    tick();
    #1;
    check("rst-burst beat3 tx_write", tx_write, 1);
    #2;
    reset = 1; m0_read = 1; rx_readdatavalid = 1;
    #1;
    check("rst-burst tx_write", tx_write, 0);
    check("rst-burst rx_read", rx_read, 0);
    check("rst-burst m0_rdv", m0_readdatavalid, 0);
    check("rst-burst m1_wait", m1_waitrequest, 1);
    tick();
    reset = 0;
    m1_write = 0; m0_read = 0;
    m0_write = 1; m0_burstcount = 1; m0_address = 'h70;
    #1;
    check("post-rst tx_write", tx_write, 1);
    check("post-rst tx_address", tx_address, 'h70);
    check("post-rst m0_wait", m0_waitrequest, 0);
    check("post-rst m0_rdv", m0_readdatavalid, 0);
    check("post-rst m1_rdv", m1_readdatavalid, 0);
    tick();
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
